// File: rtl/cover_pkg.sv
// Shared types and constants for the toggle-coverage drain logic.
package cover_pkg;

    localparam int COVER_TOTAL = 38253;

    typedef logic [63:0] cover_index_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } cover_state_e;

endpackage

// File: rtl/rr_prio_pick.sv
// Round-robin picker: lowest set request at or above ptr, otherwise lowest set request overall.
module rr_prio_pick #(
    parameter int WIDTH = 130,
    parameter int PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             any,
    output logic [PW-1:0]    sel
);

    logic [WIDTH-1:0] upper_mask;
    logic [WIDTH-1:0] upper_req;
    logic [PW-1:0]    sel_upper;
    logic [PW-1:0]    sel_lower;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign upper_mask[gi] = (PW'(gi) >= ptr);
        end
    endgenerate

    assign upper_req = req & upper_mask;

    // Descending scan so the last assignment wins, leaving the lowest set bit.
    always_comb begin
        sel_upper = '0;
        sel_lower = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
                sel_upper = PW'(i);
            end
            if (req[i]) begin
                sel_lower = PW'(i);
            end
        end
    end

    assign any = |req;
    assign sel = (|upper_req) ? sel_upper : sel_lower;

endmodule

// File: rtl/cover_toggle_drain.sv
// Collects toggle-coverage hits and drains each newly hit point once per epoch
// as a valid/ready stream of global cover indices.
module cover_toggle_drain
    import cover_pkg::cover_index_t;
    import cover_pkg::cover_state_e;
    import cover_pkg::IDLE;
    import cover_pkg::PRESENT;
#(
    parameter int WIDTH       = 130,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = cover_pkg::COVER_TOTAL,
    localparam int PW         = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CW         = $clog2(WIDTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   valid,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output cover_index_t       out_index,
    output logic [CW-1:0]      hit_count,
    output logic               all_hit
);

    cover_state_e     state_reg, state_next;
    logic [WIDTH-1:0] pending_reg, pending_next;
    logic [WIDTH-1:0] reported_reg, reported_next;
    logic [PW-1:0]    ptr_reg, ptr_next;
    logic [PW-1:0]    sel_reg, sel_next;
    logic [CW-1:0]    hit_count_reg, hit_count_next;
    cover_index_t     out_index_reg, out_index_next;

    logic             present;
    logic             handshake;
    logic [WIDTH-1:0] sel_onehot;
    logic [WIDTH-1:0] retire_mask;
    logic [WIDTH-1:0] pending_keep;
    logic [PW-1:0]    sel_inc;
    logic [WIDTH-1:0] pick_req;
    logic [PW-1:0]    pick_ptr;
    logic             pick_any;
    logic [PW-1:0]    pick_sel;

    assign present     = (state_reg == PRESENT);
    assign handshake   = present && out_ready;
    assign sel_onehot  = WIDTH'(1) << sel_reg;
    assign retire_mask = handshake ? sel_onehot : '0;
    assign sel_inc     = (sel_reg == PW'(WIDTH - 1)) ? '0 : sel_reg + 1'b1;

    // While presenting, look ahead past the current beat so a handshake can
    // load the next winner on the same edge.
    assign pick_req = present ? (pending_reg & ~sel_onehot) : pending_reg;
    assign pick_ptr = present ? sel_inc : ptr_reg;

    rr_prio_pick #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .any (pick_any),
        .sel (pick_sel)
    );

    always_comb begin
        pending_keep   = '0;
        reported_next  = reported_reg;
        hit_count_next = hit_count_reg;
        ptr_next       = ptr_reg;
        state_next     = state_reg;
        sel_next       = sel_reg;
        out_index_next = out_index_reg;

        // A clear starts a new epoch, but the beat on the wire survives it and,
        // if accepted now or later, counts as the first report of that epoch.
        if (clear) begin
            reported_next  = retire_mask;
            pending_keep   = (present && !handshake) ? sel_onehot : '0;
            hit_count_next = handshake ? CW'(1) : '0;
            ptr_next       = handshake ? sel_inc : (present ? ptr_reg : '0);
        end else begin
            reported_next  = reported_reg | retire_mask;
            pending_keep   = pending_reg & ~retire_mask;
            hit_count_next = hit_count_reg + CW'(handshake);
            ptr_next       = handshake ? sel_inc : ptr_reg;
        end

        pending_next = pending_keep | (valid & ~reported_next);

        case (state_reg)
            IDLE: begin
                if (!clear && pick_any) begin
                    state_next     = PRESENT;
                    sel_next       = pick_sel;
                    out_index_next = cover_index_t'(COVER_INDEX) + cover_index_t'(pick_sel);
                end
            end
            PRESENT: begin
                if (handshake) begin
                    if (!clear && pick_any) begin
                        sel_next       = pick_sel;
                        out_index_next = cover_index_t'(COVER_INDEX) + cover_index_t'(pick_sel);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            reported_reg  <= '0;
            ptr_reg       <= '0;
            sel_reg       <= '0;
            hit_count_reg <= '0;
            out_index_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            reported_reg  <= reported_next;
            ptr_reg       <= ptr_next;
            sel_reg       <= sel_next;
            hit_count_reg <= hit_count_next;
            out_index_reg <= out_index_next;
        end
    end

    assign out_valid = present;
    assign out_index = out_index_reg;
    assign hit_count = hit_count_reg;
    assign all_hit   = (hit_count_reg == CW'(WIDTH));

    assert property (@(posedge clock) disable iff (reset)
        out_valid |-> (out_index < cover_index_t'(COVER_TOTAL)));

endmodule
